// File: rtl/cbus_mem_responder_if.sv
// cbus_if: cache-bus request/response bundle between an initiator and a memory responder
interface cbus_if;
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic [3:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;
  modport master (
    output creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data, creq_len, creq_burst,
    input  cresp_ready, cresp_last, cresp_data
  );
  modport slave (
    input  creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data, creq_len, creq_burst,
    output cresp_ready, cresp_last, cresp_data
  );
endinterface

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: memory-side cbus endpoint serving one burst at a time from a word array
module cbus_mem_responder #(
  parameter int MEM_WORDS    = 65536,
  parameter int LATENCY      = 2,
  parameter int STALL_PERIOD = 0
) (
  input logic   clk,
  input logic   reset,
  cbus_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t        state_q, state_d;
  logic [15:0]   wait_q, wait_d, run_q, run_d;
  logic [3:0]    beat_q, beat_d, len_q, len_d;
  logic [AW-1:0] base_q, base_d, idx;
  logic          is_wr_q, is_wr_d, fixed_q, fixed_d;
  logic          ready, last, bubble, unused_ok;
  logic [63:0]   mem [MEM_WORDS];
  assign unused_ok = ^{bus.creq_size, bus.creq_addr[63:AW+3], bus.creq_addr[2:0]};
  assign idx = fixed_q ? base_q : base_q + AW'(beat_q);
  // run_q counts beats since the last bubble; the burst ends before a bubble can follow the final beat
  assign bubble = STALL_PERIOD != 0 && run_q == 16'(STALL_PERIOD);
  assign ready = state_q == BURST && bus.creq_valid && !bubble && !reset;
  assign last = ready && beat_q == len_q;
  assign bus.cresp_ready = ready;
  assign bus.cresp_last = last;
  assign bus.cresp_data = ready && !is_wr_q ? mem[idx] : '0;
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    run_d   = run_q;
    beat_d  = beat_q;
    len_d   = len_q;
    base_d  = base_q;
    is_wr_d = is_wr_q;
    fixed_d = fixed_q;
    case (state_q)
      IDLE: if (bus.creq_valid) begin
        is_wr_d = bus.creq_is_write;
        fixed_d = bus.creq_burst == 2'b00;
        base_d  = bus.creq_addr[AW+2:3];
        len_d   = bus.creq_len;
        beat_d  = '0;
        run_d   = '0;
        wait_d  = 16'(LATENCY);
        state_d = LATENCY == 0 ? BURST : WAIT;
      end
      WAIT: begin
        wait_d  = wait_q - 16'd1;
        state_d = !bus.creq_valid ? IDLE : wait_q == 16'd1 ? BURST : WAIT;
      end
      BURST: begin
        state_d = !bus.creq_valid || last ? IDLE : BURST;
        beat_d  = ready ? beat_q + 4'd1 : beat_q;
        run_d   = bubble ? '0 : ready ? run_q + 16'd1 : run_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      run_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      base_q  <= '0;
      is_wr_q <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      base_q  <= base_d;
      is_wr_q <= is_wr_d;
      fixed_q <= fixed_d;
    end
  always_ff @(posedge clk)
    if (ready && is_wr_q)
      for (int i = 0; i < 8; i++)
        if (bus.creq_strobe[i]) mem[idx][8*i +: 8] <= bus.creq_data[8*i +: 8];
endmodule
